regfile_bypass: RTL

Parametrised general-purpose register file for the pipelined CPU datapath. It replaces the fixed 2-read/1-write array with the following:
- N combinational read ports.
- Two prioritised write ports: ALU writeback and load writeback.
- Same-cycle write-to-read bypass.
- Hardware-zeroed register 0.
- A reset-triggered clear sequencer that zeroes the array one entry per cycle, so no preload file is needed.

It sits between decode (read addresses) and writeback (write ports).

---
 rtl/regfile_bypass_if.sv | 25 ++
 rtl/regfile_bypass.sv | 59 +++++
 2 files changed

// File: rtl/regfile_bypass_if.sv
// regfile_bypass_if: read/write bundle between decode/writeback (master) and the register file (slave)
interface regfile_bypass_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_READ = 2
);
  logic [N_READ*ADDR_W-1:0] rd_addr;
  logic [N_READ*DATA_W-1:0] rd_data;
  logic                     wa_en;
  logic [ADDR_W-1:0]        wa_addr;
  logic [DATA_W-1:0]        wa_data;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     init_busy;
  logic                     wr_collide;
  modport master (
    output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
    input  rd_data, init_busy, wr_collide
  );
  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
    output rd_data, init_busy, wr_collide
  );
endinterface

// File: rtl/regfile_bypass.sv
// regfile_bypass: N-read, 2-write (B wins) register file with same-cycle bypass, zero reg and reset clear sweep
// Ports: clk, reset (sync, active-low), bus (slave: rd_addr/rd_data, wa_*, wb_*, init_busy, wr_collide)
module regfile_bypass #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_READ   = 2,
  parameter int ZERO_REG = 1
) (
  input logic             clk,
  input logic             reset,
  regfile_bypass_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;
  logic [0:0]                state;
  logic [ADDR_W-1:0]         clr_idx;
  logic [DATA_W-1:0]         mem [DEPTH];
  logic                      collide;
  logic                      wa_ok;
  logic                      wb_ok;
  logic [N_READ*DATA_W-1:0]  rd;
  logic [ADDR_W-1:0]         a;
  assign wa_ok = state == RUN && bus.wa_en && !(ZERO_REG != 0 && bus.wa_addr == '0);
  assign wb_ok = state == RUN && bus.wb_en && !(ZERO_REG != 0 && bus.wb_addr == '0);
  always_ff @(posedge clk)
    if (!reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
      collide <= 1'b0;
    end else begin
      collide <= wa_ok && wb_ok && bus.wa_addr == bus.wb_addr;
      if (state == CLEAR) begin
        clr_idx <= clr_idx + 1'b1;
        if (&clr_idx) state <= RUN;
      end
    end
  // Array is left untouched on reset edges; B is written last so it wins a same-address tie.
  always_ff @(posedge clk)
    if (reset) begin
      if (state == CLEAR) mem[clr_idx] <= '0;
      if (wa_ok) mem[bus.wa_addr] <= bus.wa_data;
      if (wb_ok) mem[bus.wb_addr] <= bus.wb_data;
    end
  // Bypass order mirrors write priority so a read always matches the next committed value.
  always_comb begin
    rd = '0;
    a  = '0;
    for (int i = 0; i < N_READ; i++) begin
      a = bus.rd_addr[i*ADDR_W +: ADDR_W];
      rd[i*DATA_W +: DATA_W] = state == CLEAR || (ZERO_REG != 0 && a == '0) ? '0 :
                               bus.wb_en && bus.wb_addr == a ? bus.wb_data :
                               bus.wa_en && bus.wa_addr == a ? bus.wa_data : mem[a];
    end
  end
  assign bus.rd_data    = rd;
  assign bus.init_busy  = state == CLEAR;
  assign bus.wr_collide = collide;
endmodule
